// File: rtl/sc_readback_pkg.sv
// Shared constants and types for the slow-control readback checker.
package sc_readback_pkg;

  localparam int unsigned BITS_PER_ASIC_DEFAULT = 592;
  localparam int unsigned BITS_READ_REG_DEFAULT = 64;
  localparam int unsigned CNT_W                 = 13;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

endpackage

// File: rtl/sc_crc16_serial.sv
// Serial MSB-first CRC-16-CCITT accumulator (poly 0x1021, init 0xFFFF).
module sc_crc16_serial
  import sc_readback_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/sc_readback_checker.sv
// Compares the CRC of the bits read back from the daisy chain against the CRC of the
// previously loaded frame. Optional saturating error counter: SC_READBACK_ERRCNT_EN.
module sc_readback_checker
  import sc_readback_pkg::*;
#(
  parameter int unsigned BITS_PER_ASIC = BITS_PER_ASIC_DEFAULT,
  parameter int unsigned BITS_READ_REG = BITS_READ_REG_DEFAULT
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             Frame_start,
  input  logic             Bit_strobe,
  input  logic             Sr_in_bit,
  input  logic             SR_OUT,
  input  logic             sc_or_read,
  input  logic [2:0]       asic_num,
  output logic             Readback_valid,
  output logic             Readback_ok,
  output logic             Len_error,
  output logic [CNT_W-1:0] Bit_count,
  output logic [15:0]      Crc_tx,
  output logic [15:0]      Crc_rx,
  output logic [15:0]      Err_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, frame_len, count_next;
  logic             mode_q, prev_mode_q, prev_valid_q;
  logic [15:0]      prev_tx_crc_q, tx_crc, rx_crc;
  logic             sr_s1, sr_s2;
  logic             pending_q;
  logic             crc_init, crc_en, start_ok, len_err_d, do_check, abort, set_pending;
  logic             compare_en, crc_match;

  assign frame_len  = CNT_W'(asic_num) *
                      CNT_W'(sc_or_read ? BITS_READ_REG : BITS_PER_ASIC);
  assign count_next = Bit_count + 1'b1;
  assign compare_en = do_check && prev_valid_q && (prev_mode_q == mode_q);
  assign crc_match  = (rx_crc == prev_tx_crc_q);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_s1 <= 1'b0;
      sr_s2 <= 1'b0;
    end else begin
      sr_s1 <= SR_OUT;
      sr_s2 <= sr_s1;
    end
  end

  sc_crc16_serial u_crc_tx (
    .clk    (Clk),
    .reset_n(reset_n),
    .init   (crc_init),
    .en     (crc_en),
    .din    (Sr_in_bit),
    .crc    (tx_crc)
  );

  sc_crc16_serial u_crc_rx (
    .clk    (Clk),
    .reset_n(reset_n),
    .init   (crc_init),
    .en     (crc_en),
    .din    (sr_s2),
    .crc    (rx_crc)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    start_ok    = 1'b0;
    len_err_d   = 1'b0;
    do_check    = 1'b0;
    abort       = 1'b0;
    set_pending = 1'b0;
    case (state_q)
      IDLE: begin
        if (Frame_start || pending_q) begin
          if (asic_num != '0) begin
            start_ok = 1'b1;
            crc_init = 1'b1;
            state_d  = SHIFT;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A restart takes precedence over a coincident strobe.
        if (Frame_start) begin
          abort     = 1'b1;
          len_err_d = 1'b1;
          if (asic_num != '0) begin
            start_ok = 1'b1;
            crc_init = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (Bit_strobe) begin
          crc_en = 1'b1;
          if (count_next == len_q) state_d = CHECK;
        end
      end
      CHECK: begin
        do_check    = 1'b1;
        set_pending = Frame_start;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q          <= '0;
      mode_q         <= 1'b0;
      prev_mode_q    <= 1'b0;
      prev_valid_q   <= 1'b0;
      prev_tx_crc_q  <= '0;
      pending_q      <= 1'b0;
      Readback_valid <= 1'b0;
      Readback_ok    <= 1'b0;
      Len_error      <= 1'b0;
      Bit_count      <= '0;
      Crc_tx         <= '0;
      Crc_rx         <= '0;
    end else begin
      Readback_valid <= 1'b0;
      Len_error      <= len_err_d;
      pending_q      <= set_pending;
      if (start_ok) begin
        len_q     <= frame_len;
        mode_q    <= sc_or_read;
        Bit_count <= '0;
      end else if (crc_en) begin
        Bit_count <= count_next;
      end
      if (abort) prev_valid_q <= 1'b0;
      if (do_check) begin
        Crc_tx        <= tx_crc;
        Crc_rx        <= rx_crc;
        prev_tx_crc_q <= tx_crc;
        prev_valid_q  <= 1'b1;
        prev_mode_q   <= mode_q;
        if (compare_en) begin
          Readback_valid <= 1'b1;
          Readback_ok    <= crc_match;
        end
      end
    end
  end

`ifdef SC_READBACK_ERRCNT_EN
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Err_count <= '0;
    end else if (compare_en && !crc_match && (Err_count != '1)) begin
      Err_count <= Err_count + 1'b1;
    end
  end
`else
  assign Err_count = '0;
`endif

endmodule

// File: tb/tb_sc_readback_checker.sv
// Scoreboard bench for sc_readback_checker: readback match/mismatch, aborts, modes, reset.
module tb_sc_readback_checker;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Frame_start = 1'b0;
  logic        Bit_strobe = 1'b0;
  logic        Sr_in_bit = 1'b0;
  logic        SR_OUT = 1'b0;
  logic        sc_or_read = 1'b0;
  logic [2:0]  asic_num = 3'd1;
  logic        Readback_valid, Readback_ok, Len_error;
  logic [12:0] Bit_count;
  logic [15:0] Crc_tx, Crc_rx, Err_count;

  sc_readback_checker #(.BITS_PER_ASIC(592), .BITS_READ_REG(64)) dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .Frame_start   (Frame_start),
    .Bit_strobe    (Bit_strobe),
    .Sr_in_bit     (Sr_in_bit),
    .SR_OUT        (SR_OUT),
    .sc_or_read    (sc_or_read),
    .asic_num      (asic_num),
    .Readback_valid(Readback_valid),
    .Readback_ok   (Readback_ok),
    .Len_error     (Len_error),
    .Bit_count     (Bit_count),
    .Crc_tx        (Crc_tx),
    .Crc_rx        (Crc_rx),
    .Err_count     (Err_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ok;
    logic [15:0] crc_rx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   valid_seen = 0;
  int   len_err_seen = 0;

  logic pat_a [0:4143];
  logic pat_b [0:4143];
  logic tx_pat [0:4143];
  logic rx_pat [0:4143];

  logic        m_prev_valid = 1'b0;
  logic        m_prev_mode = 1'b0;
  logic [15:0] m_prev_tx = 16'h0;
  int          m_exp_err = 0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Readback monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge Clk) begin
    if (reset_n && Len_error) len_err_seen++;
    if (reset_n && Readback_valid) begin
      valid_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got Readback_valid=1 ok=%0b, required no pulse", Readback_ok);
      end else begin
        mon_e = exp_q.pop_front();
        if (Readback_ok !== mon_e.ok || Crc_rx !== mon_e.crc_rx) begin
          fails++;
          $display("FAIL readback_result: got ok=%0b crc_rx=%h, required ok=%0b crc_rx=%h",
                   Readback_ok, Crc_rx, mon_e.ok, mon_e.crc_rx);
        end
      end
    end
  end

  task automatic load_pats(input int tsel, input int rsel, input int flip_idx);
    for (int i = 0; i < 4144; i++) begin
      tx_pat[i] = (tsel == 1) ? pat_a[i] : (tsel == 2) ? pat_b[i] : 1'b0;
      rx_pat[i] = (rsel == 1) ? pat_a[i] : (rsel == 2) ? pat_b[i] : 1'b0;
    end
    if (flip_idx >= 0) rx_pat[flip_idx] = ~rx_pat[flip_idx];
  endtask

  task automatic pulse_start();
    @(negedge Clk) Frame_start = 1'b1;
    @(negedge Clk) Frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic t, input logic r);
    @(negedge Clk);
    Sr_in_bit = t;
    SR_OUT    = r;
    repeat (2) @(negedge Clk);
    Bit_strobe = 1'b1;
    @(negedge Clk) Bit_strobe = 1'b0;
  endtask

  task automatic run_frame(input string name, input int nbits, input logic mode,
                           input logic [2:0] asic, input int exp_valid);
    int          v0, ec;
    logic [15:0] tcrc, rcrc;
    sc_or_read = mode;
    asic_num   = asic;
    v0   = valid_seen;
    tcrc = 16'hFFFF;
    rcrc = 16'hFFFF;
    pulse_start();
    for (int i = 0; i < nbits; i++) begin
      send_bit(tx_pat[i], rx_pat[i]);
      tcrc = crc_step(tcrc, tx_pat[i]);
      rcrc = crc_step(rcrc, rx_pat[i]);
    end
    if (m_prev_valid && m_prev_mode == mode) begin
      exp_q.push_back('{ok: (rcrc == m_prev_tx), crc_rx: rcrc});
      if (rcrc != m_prev_tx && m_exp_err < 65535) m_exp_err++;
    end
    m_prev_tx    = tcrc;
    m_prev_valid = 1'b1;
    m_prev_mode  = mode;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
`ifdef SC_READBACK_ERRCNT_EN
    ec = m_exp_err;
`else
    ec = 0;
`endif
    tests += 6;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_pending: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    if (valid_seen - v0 !== exp_valid) begin
      fails++;
      $display("FAIL %s_valid_pulses: got %0d, required %0d", name, valid_seen - v0, exp_valid);
    end
    if (Crc_tx !== tcrc) begin
      fails++;
      $display("FAIL %s_crc_tx: got %h, required %h", name, Crc_tx, tcrc);
    end
    if (Crc_rx !== rcrc) begin
      fails++;
      $display("FAIL %s_crc_rx: got %h, required %h", name, Crc_rx, rcrc);
    end
    if (Bit_count !== 13'(nbits)) begin
      fails++;
      $display("FAIL %s_bit_count: got %0d, required %0d", name, Bit_count, nbits);
    end
    if (Err_count !== 16'(ec)) begin
      fails++;
      $display("FAIL %s_err_count: got %0d, required %0d", name, Err_count, ec);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    tests++;
    if ({Readback_valid, Readback_ok, Len_error, Bit_count, Crc_tx, Crc_rx, Err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b ok=%0b le=%0b cnt=%0d tx=%h rx=%h ec=%0d, required all 0",
               Readback_valid, Readback_ok, Len_error, Bit_count, Crc_tx, Crc_rx, Err_count);
    end
    reset_n = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    tests++;
    if (Bit_count !== 13'd0) begin
      fails++;
      $display("FAIL idle_strobe_ignored: got Bit_count=%0d, required 0", Bit_count);
    end
  endtask

  task automatic test_readback();
    load_pats(1, 0, -1);
    run_frame("frame1", 592, 1'b0, 3'd1, 0);
    load_pats(2, 1, -1);
    run_frame("frame2", 592, 1'b0, 3'd1, 1);
    tests++;
    if (Readback_ok !== 1'b1) begin
      fails++;
      $display("FAIL frame2_ok_held: got %0b, required 1", Readback_ok);
    end
  endtask

  task automatic test_mismatch();
    load_pats(1, 2, 300);
    run_frame("mismatch", 592, 1'b0, 3'd1, 1);
    tests++;
    if (Readback_ok !== 1'b0) begin
      fails++;
      $display("FAIL mismatch_ok_held: got %0b, required 0", Readback_ok);
    end
  endtask

  task automatic test_abort();
    int le0;
    le0 = len_err_seen;
    load_pats(2, 1, -1);
    sc_or_read = 1'b0;
    asic_num   = 3'd1;
    pulse_start();
    for (int i = 0; i < 100; i++) send_bit(tx_pat[i], rx_pat[i]);
    m_prev_valid = 1'b0;
    load_pats(1, 1, -1);
    run_frame("after_abort", 592, 1'b0, 3'd1, 0);
    tests++;
    if (len_err_seen - le0 !== 1) begin
      fails++;
      $display("FAIL abort_len_error: got %0d pulses, required 1", len_err_seen - le0);
    end
    load_pats(2, 1, -1);
    run_frame("reprimed", 592, 1'b0, 3'd1, 1);
  endtask

  task automatic test_zero_asic();
    int          le0;
    logic [12:0] cnt0;
    le0  = len_err_seen;
    cnt0 = Bit_count;
    asic_num = 3'd0;
    pulse_start();
    repeat (2) @(negedge Clk);
    send_bit(1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    tests += 2;
    if (len_err_seen - le0 !== 1) begin
      fails++;
      $display("FAIL zero_asic_len_error: got %0d pulses, required 1", len_err_seen - le0);
    end
    if (Bit_count !== cnt0) begin
      fails++;
      $display("FAIL zero_asic_bit_count: got %0d, required %0d", Bit_count, cnt0);
    end
    asic_num = 3'd1;
  endtask

  task automatic test_read_mode();
    load_pats(1, 0, -1);
    run_frame("read1", 256, 1'b1, 3'd4, 0);
    load_pats(2, 1, -1);
    run_frame("read2", 256, 1'b1, 3'd4, 1);
    load_pats(1, 2, -1);
    run_frame("sc_reprime", 592, 1'b0, 3'd1, 0);
    load_pats(2, 1, -1);
    run_frame("sc_after_reprime", 592, 1'b0, 3'd1, 1);
  endtask

  task automatic test_reset_mid_frame();
    load_pats(1, 2, -1);
    asic_num = 3'd1;
    sc_or_read = 1'b0;
    pulse_start();
    for (int i = 0; i < 50; i++) send_bit(tx_pat[i], rx_pat[i]);
    @(negedge Clk) reset_n = 1'b0;
    #1;
    tests++;
    if ({Readback_ok, Bit_count, Crc_tx, Crc_rx, Err_count} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got ok=%0b cnt=%0d tx=%h rx=%h ec=%0d, required all 0",
               Readback_ok, Bit_count, Crc_tx, Crc_rx, Err_count);
    end
    m_prev_valid = 1'b0;
    m_exp_err    = 0;
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    load_pats(1, 1, -1);
    run_frame("post_reset", 592, 1'b0, 3'd1, 0);
  endtask

  initial begin
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    for (int i = 0; i < 4144; i++) begin
      pat_a[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    lfsr = 16'h1D2B;
    for (int i = 0; i < 4144; i++) begin
      pat_b[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    test_reset();
    test_readback();
    test_mismatch();
    test_abort();
    test_zero_asic();
    test_read_mode();
    test_reset_mid_frame();
    repeat (4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
